// File: rtl/rx_escape.sv
// Receive-side escape stripper: ESC,ESC yields a literal ESC data byte, ESC,X yields command X.
// Data bytes are buffered in a small FIFO toward the TAP; an optional timer abandons a dangling ESC.
module rx_escape #(
  parameter logic [7:0] ESC     = 8'hB1,
  parameter int         DEPTH   = 2,
  parameter int         TIMEOUT = 0
) (
  input  logic       CLK_I,
  input  logic       RST_NI,
  input  logic [7:0] DATA_REC_I,
  input  logic       RX_VALID_I,
  output logic [7:0] DATA_REC_O,
  output logic       RX_VALID_O,
  input  logic       READ_I,
  output logic [7:0] COMMAND_O,
  output logic       COMMAND_VALID_O,
  output logic       TIMEOUT_O,
  output logic       OVERFLOW_O,
  input  logic       CLEAR_OVF_I
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TLAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic {
    IDLE,
    ESC_SEEN
  } state_e;

  state_e        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [7:0]    cmd_q, cmd_d;
  logic          cmd_valid_q, cmd_valid_d;
  logic          timeout_q, timeout_d;
  logic          ovf_q, ovf_d;
  logic [7:0]    mem [DEPTH];

  logic push, pop, wr_en, empty, full;

  // NOTE: every signal assigned in this block gets a default first, so no latch can be inferred.
  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    cmd_d       = cmd_q;
    cmd_valid_d = 1'b0;
    timeout_d   = 1'b0;
    push        = 1'b0;
    case (state_q)
      IDLE: begin
        if (RX_VALID_I) begin
          if (DATA_REC_I == ESC) begin
            state_d = ESC_SEEN;
            timer_d = '0;
          end else begin
            push = 1'b1;
          end
        end
      end
      ESC_SEEN: begin
        // A strobe in the expiry cycle is decoded and suppresses the timeout.
        if (RX_VALID_I) begin
          state_d = IDLE;
          if (DATA_REC_I == ESC) begin
            push = 1'b1;
          end else begin
            cmd_d       = DATA_REC_I;
            cmd_valid_d = 1'b1;
          end
        end else if (TIMEOUT != 0) begin
          if (timer_q == TLAST) begin
            state_d   = IDLE;
            timeout_d = 1'b1;
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  always_comb begin
    empty    = (wr_ptr_q == rd_ptr_q);
    full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    pop      = READ_I && !empty;
    wr_en    = push && (!full || pop);
    wr_ptr_d = wr_ptr_q + PW'(wr_en);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    if (push && full && !pop) begin
      ovf_d = 1'b1;
    end else if (CLEAR_OVF_I) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // NOTE: state is updated with non-blocking assignments so all flops sample pre-edge values.
  always_ff @(posedge CLK_I or negedge RST_NI) begin
    if (!RST_NI) begin
      state_q     <= IDLE;
      timer_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cmd_q       <= '0;
      cmd_valid_q <= 1'b0;
      timeout_q   <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cmd_q       <= cmd_d;
      cmd_valid_q <= cmd_valid_d;
      timeout_q   <= timeout_d;
      ovf_q       <= ovf_d;
    end
  end

  // NOTE: storage is not reset; the output mux forces zero while the FIFO is empty.
  always_ff @(posedge CLK_I) begin
    if (wr_en) begin
      mem[wr_ptr_q[AW-1:0]] <= DATA_REC_I;
    end
  end

  assign DATA_REC_O      = empty ? 8'h00 : mem[rd_ptr_q[AW-1:0]];
  assign RX_VALID_O      = !empty;
  assign COMMAND_O       = cmd_q;
  assign COMMAND_VALID_O = cmd_valid_q;
  assign TIMEOUT_O       = timeout_q;
  assign OVERFLOW_O      = ovf_q;

endmodule
